// File: rtl/tl_source_merger_if.sv
// TileLink channel bundle (A-E) for the TL-UL/TL-UH subset.
// B, C and E carry only their handshake pair; nothing in this design uses their payloads.
interface tl_channel #(
   parameter int SourceWidth = 4,
   parameter int SinkWidth   = 1,
   parameter int AddrWidth   = 56,
   parameter int DataWidth   = 64,
   parameter int SizeWidth   = 3
);
   logic                     a_valid;
   logic                     a_ready;
   logic [2:0]               a_opcode;
   logic [2:0]               a_param;
   logic [SizeWidth-1:0]     a_size;
   logic [SourceWidth-1:0]   a_source;
   logic [AddrWidth-1:0]     a_address;
   logic [DataWidth/8-1:0]   a_mask;
   logic [DataWidth-1:0]     a_data;
   logic                     a_corrupt;

   logic                     b_valid;
   logic                     b_ready;
   logic                     c_valid;
   logic                     c_ready;

   logic                     d_valid;
   logic                     d_ready;
   logic [2:0]               d_opcode;
   logic [1:0]               d_param;
   logic [SizeWidth-1:0]     d_size;
   logic [SourceWidth-1:0]   d_source;
   logic [SinkWidth-1:0]     d_sink;
   logic                     d_denied;
   logic [DataWidth-1:0]     d_data;
   logic                     d_corrupt;

   logic                     e_valid;
   logic                     e_ready;

   // Seen from the side that issues requests.
   modport host (
      output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
      output b_ready, c_valid, d_ready, e_valid,
      input  a_ready, b_valid, c_ready, e_ready,
      input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt
   );

   // Seen from the side that serves requests.
   modport device (
      input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
      input  b_ready, c_valid, d_ready, e_valid,
      output a_ready, b_valid, c_ready, e_ready,
      output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt
   );
endinterface

// File: rtl/tl_source_merger.sv
// tl_source_merger: merges two TileLink hosts (disjoint source ranges) onto one device link.
// A requests are arbitrated round-robin with message locking; D responses are routed back
// by comparing d_source against host1's range. B/C/E are tied off.
// Optional feature: define TL_SOURCE_MERGER_A_REG_EN to insert a one-entry register slice
// between the arbiter and the device A channel (one extra cycle of latency, full throughput).
module tl_source_merger #(
   parameter int SourceWidth = 4,
   parameter int SinkWidth   = 1,
   parameter int AddrWidth   = 56,
   parameter int DataWidth   = 64,
   parameter int SizeWidth   = 3,
   parameter logic [SourceWidth-1:0] Host1Base = SourceWidth'(8),
   parameter logic [SourceWidth-1:0] Host1Mask = SourceWidth'(7)
) (
   input  logic        clk_i,
   input  logic        rst_i,
   tl_channel.device   host0,
   tl_channel.device   host1,
   tl_channel.host     device
);

   localparam int Lanes    = DataWidth / 8;
   localparam int LaneBits = $clog2(Lanes);

   // All three links must agree with the module's view of the field widths.
   if (host0.SourceWidth != SourceWidth || host1.SourceWidth != SourceWidth ||
       device.SourceWidth != SourceWidth || host0.SinkWidth != SinkWidth ||
       host1.SinkWidth != SinkWidth || device.SinkWidth != SinkWidth ||
       host0.AddrWidth != AddrWidth || host1.AddrWidth != AddrWidth ||
       device.AddrWidth != AddrWidth || host0.DataWidth != DataWidth ||
       host1.DataWidth != DataWidth || device.DataWidth != DataWidth ||
       host0.SizeWidth != SizeWidth || host1.SizeWidth != SizeWidth ||
       device.SizeWidth != SizeWidth) begin : g_width_mismatch
      $fatal(1, "tl_source_merger: link widths differ from module parameters");
   end

   if (DataWidth < 8 || (DataWidth & (DataWidth - 1)) != 0) begin : g_bad_data_width
      $fatal(1, "tl_source_merger: DataWidth must be a power of two and at least 8");
   end

   typedef struct packed {
      logic [2:0]             opcode;
      logic [2:0]             param;
      logic [SizeWidth-1:0]   size;
      logic [SourceWidth-1:0] source;
      logic [AddrWidth-1:0]   address;
      logic [Lanes-1:0]       mask;
      logic [DataWidth-1:0]   data;
      logic                   corrupt;
   } a_beat_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1,
      BURST = 2'd2
   } arb_state_e;

   // Number of beats minus one for an A message: data-carrying opcodes (0..3) span
   // 2^size bytes over the bus width; Get/Intent are always a single beat.
   function automatic logic [SizeWidth-1:0] calc_beats_m1(input logic [2:0] opcode,
                                                         input logic [SizeWidth-1:0] size);
      int shift;
      calc_beats_m1 = '0;
      shift = int'(size) - LaneBits;
      if (opcode <= 3'd3 && shift > 0) begin
         calc_beats_m1 = SizeWidth'((1 << shift) - 1);
      end
   endfunction

   a_beat_t              host_beat     [2];
   logic [1:0]           host_valid;
   logic [1:0]           host_ready;
   logic [SizeWidth-1:0] host_beats_m1 [2];

   arb_state_e           state_reg;
   logic                 grant_reg;
   logic                 ptr_reg;
   logic [SizeWidth-1:0] cnt_reg;

   logic                 grant_sel;
   logic                 arb_valid;
   logic                 arb_ready;
   logic                 arb_last;
   logic                 arb_hs;
   a_beat_t              arb_beat;

   logic                 dev_valid;
   a_beat_t              dev_beat;

   // ------------------------------------------------------------------ host A capture
   assign host_valid[0] = host0.a_valid;
   assign host_valid[1] = host1.a_valid;

   assign host_beat[0] = '{opcode: host0.a_opcode, param: host0.a_param, size: host0.a_size,
                           source: host0.a_source, address: host0.a_address,
                           mask: host0.a_mask, data: host0.a_data, corrupt: host0.a_corrupt};
   assign host_beat[1] = '{opcode: host1.a_opcode, param: host1.a_param, size: host1.a_size,
                           source: host1.a_source, address: host1.a_address,
                           mask: host1.a_mask, data: host1.a_data, corrupt: host1.a_corrupt};

   for (genvar gi = 0; gi < 2; gi++) begin : g_host
      assign host_beats_m1[gi] = calc_beats_m1(host_beat[gi].opcode, host_beat[gi].size);
      // Only the granted host sees the downstream ready; nothing is accepted in reset.
      assign host_ready[gi]    = ~rst_i & (grant_sel == 1'(gi)) & arb_ready;
   end

   assign host0.a_ready = host_ready[0];
   assign host1.a_ready = host_ready[1];

   // ------------------------------------------------------------------ arbitration
   // Pick the forwarded host: fresh choice in IDLE, frozen grant in HOLD and BURST.
   always_comb begin
      grant_sel = grant_reg;
      if (state_reg == IDLE) begin
         if (host_valid == 2'b11) begin
            grant_sel = ptr_reg;
         end else begin
            grant_sel = host_valid[1];
         end
      end
      arb_valid = host_valid[grant_sel] & ~rst_i;
      arb_beat  = host_beat[grant_sel];
      // In BURST the counter tracks remaining beats; otherwise this beat is the first.
      if (state_reg == BURST) begin
         arb_last = (cnt_reg == SizeWidth'(1));
      end else begin
         arb_last = (host_beats_m1[grant_sel] == '0);
      end
   end

   assign arb_hs = arb_valid & arb_ready;

   // Arbiter FSM: locks the grant across stalls and multi-beat messages, rotates on last beat.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg <= IDLE;
         grant_reg <= 1'b0;
         ptr_reg   <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE, HOLD: begin
               if (arb_hs) begin
                  grant_reg <= grant_sel;
                  if (arb_last) begin
                     ptr_reg   <= ~grant_sel;
                     state_reg <= IDLE;
                  end else begin
                     cnt_reg   <= host_beats_m1[grant_sel];
                     state_reg <= BURST;
                  end
               end else if (arb_valid) begin
                  grant_reg <= grant_sel;
                  state_reg <= HOLD;
               end
            end
            BURST: begin
               if (arb_hs) begin
                  cnt_reg <= cnt_reg - SizeWidth'(1);
                  if (arb_last) begin
                     ptr_reg   <= ~grant_reg;
                     state_reg <= IDLE;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------ device A output
`ifdef TL_SOURCE_MERGER_A_REG_EN
   logic    slice_valid_reg;
   a_beat_t slice_beat_reg;

   // The slice accepts a new beat whenever it is empty or being emptied this cycle.
   assign arb_ready = ~slice_valid_reg | device.a_ready;

   // One-entry A slice: refill on accept, empty when drained with nothing behind it.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         slice_valid_reg <= 1'b0;
         slice_beat_reg  <= '0;
      end else if (arb_ready) begin
         slice_valid_reg <= arb_valid;
         if (arb_valid) begin
            slice_beat_reg <= arb_beat;
         end
      end
   end

   assign dev_valid = slice_valid_reg;
   assign dev_beat  = slice_beat_reg;
`else
   assign arb_ready = device.a_ready;
   assign dev_valid = arb_valid;
   assign dev_beat  = arb_beat;
`endif

   assign device.a_valid   = dev_valid;
   assign device.a_opcode  = dev_beat.opcode;
   assign device.a_param   = dev_beat.param;
   assign device.a_size    = dev_beat.size;
   assign device.a_source  = dev_beat.source;
   assign device.a_address = dev_beat.address;
   assign device.a_mask    = dev_beat.mask;
   assign device.a_data    = dev_beat.data;
   assign device.a_corrupt = dev_beat.corrupt;

   // ------------------------------------------------------------------ D routing
   // The source is constant within a D burst, so steering by source needs no lock.
   logic d_sel1;
   assign d_sel1 = ((device.d_source & ~Host1Mask) == Host1Base);

   assign host0.d_valid  = device.d_valid & ~d_sel1;
   assign host1.d_valid  = device.d_valid & d_sel1;
   assign device.d_ready = d_sel1 ? host1.d_ready : host0.d_ready;

   assign host0.d_opcode  = device.d_opcode;
   assign host0.d_param   = device.d_param;
   assign host0.d_size    = device.d_size;
   assign host0.d_source  = device.d_source;
   assign host0.d_sink    = device.d_sink;
   assign host0.d_denied  = device.d_denied;
   assign host0.d_data    = device.d_data;
   assign host0.d_corrupt = device.d_corrupt;

   assign host1.d_opcode  = device.d_opcode;
   assign host1.d_param   = device.d_param;
   assign host1.d_size    = device.d_size;
   assign host1.d_source  = device.d_source;
   assign host1.d_sink    = device.d_sink;
   assign host1.d_denied  = device.d_denied;
   assign host1.d_data    = device.d_data;
   assign host1.d_corrupt = device.d_corrupt;

   // ------------------------------------------------------------------ B/C/E tie-offs
   assign host0.b_valid  = 1'b0;
   assign host1.b_valid  = 1'b0;
   assign host0.c_ready  = 1'b0;
   assign host1.c_ready  = 1'b0;
   assign host0.e_ready  = 1'b0;
   assign host1.e_ready  = 1'b0;
   assign device.b_ready = 1'b1;
   assign device.c_valid = 1'b0;
   assign device.e_valid = 1'b0;

   // Channel inputs that are deliberately ignored.
   logic unused_inputs;
   assign unused_inputs = ^{host0.b_ready, host0.c_valid, host0.e_valid,
                            host1.b_ready, host1.c_valid, host1.e_valid,
                            device.b_valid, device.c_ready, device.e_ready};

endmodule

// File: tb/tb_tl_source_merger.sv
// Directed self-checking bench for tl_source_merger (default zero-latency build; with
// TL_SOURCE_MERGER_A_REG_EN defined it runs the reset, D-routing and register-slice scenarios).
module tb_tl_source_merger;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   tl_channel #(.SourceWidth(4), .SinkWidth(1), .AddrWidth(56), .DataWidth(64), .SizeWidth(3)) h0 ();
   tl_channel #(.SourceWidth(4), .SinkWidth(1), .AddrWidth(56), .DataWidth(64), .SizeWidth(3)) h1 ();
   tl_channel #(.SourceWidth(4), .SinkWidth(1), .AddrWidth(56), .DataWidth(64), .SizeWidth(3)) dv ();

   tl_source_merger #(
      .SourceWidth(4), .SinkWidth(1), .AddrWidth(56), .DataWidth(64), .SizeWidth(3),
      .Host1Base(4'h8), .Host1Mask(4'h7)
   ) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .host0  (h0),
      .host1  (h1),
      .device (dv)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input int h, input logic v, input logic [2:0] op, input logic [2:0] sz,
                          input logic [3:0] src, input logic [63:0] data);
      if (h == 0) begin
         h0.a_valid = v; h0.a_opcode = op; h0.a_param = 3'd0; h0.a_size = sz; h0.a_source = src;
         h0.a_address = 56'h1000 + 56'(src); h0.a_mask = 8'hFF; h0.a_data = data; h0.a_corrupt = 1'b0;
      end else begin
         h1.a_valid = v; h1.a_opcode = op; h1.a_param = 3'd0; h1.a_size = sz; h1.a_source = src;
         h1.a_address = 56'h2000 + 56'(src); h1.a_mask = 8'hFF; h1.a_data = data; h1.a_corrupt = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      dv.a_ready = 1'b1;
      drive_a(0, 1'b1, 3'd4, 3'd3, 4'h2, 64'h0);
      drive_a(1, 1'b1, 3'd4, 3'd3, 4'hA, 64'h0);
      tick();
      tick();
      checks++; if (dv.a_valid !== 1'b0) begin errors++; $display("FAIL reset_dev_a_valid: got %b want 0", dv.a_valid); end
      checks++; if (h0.a_ready !== 1'b0) begin errors++; $display("FAIL reset_h0_a_ready: got %b want 0", h0.a_ready); end
      checks++; if (h1.a_ready !== 1'b0) begin errors++; $display("FAIL reset_h1_a_ready: got %b want 0", h1.a_ready); end
      $display("test_reset: device idle and hosts stalled while reset is high");
   endtask

   task automatic test_same_cycle();
      rst = 1'b0;
      #1;
      checks++; if (dv.a_valid !== 1'b1) begin errors++; $display("FAIL same_c0_valid: got %b want 1", dv.a_valid); end
      checks++; if (dv.a_source !== 4'h2) begin errors++; $display("FAIL same_c0_source: got %h want 2", dv.a_source); end
      checks++; if (dv.a_opcode !== 3'd4) begin errors++; $display("FAIL same_c0_opcode: got %0d want 4", dv.a_opcode); end
      checks++; if (h0.a_ready !== 1'b1) begin errors++; $display("FAIL same_c0_h0_ready: got %b want 1", h0.a_ready); end
      checks++; if (h1.a_ready !== 1'b0) begin errors++; $display("FAIL same_c0_h1_ready: got %b want 0", h1.a_ready); end
      tick();
      drive_a(0, 1'b0, 3'd4, 3'd3, 4'h2, 64'h0);
      #1;
      checks++; if (dv.a_source !== 4'hA) begin errors++; $display("FAIL same_c1_source: got %h want a", dv.a_source); end
      checks++; if (h1.a_ready !== 1'b1) begin errors++; $display("FAIL same_c1_h1_ready: got %b want 1", h1.a_ready); end
      checks++; if (h0.a_ready !== 1'b0) begin errors++; $display("FAIL same_c1_h0_ready: got %b want 0", h0.a_ready); end
      tick();
      drive_a(1, 1'b0, 3'd4, 3'd3, 4'hA, 64'h0);
      $display("test_same_cycle: host0 Get src 2 then host1 Get src a");
   endtask

   task automatic test_burst();
      drive_a(1, 1'b1, 3'd4, 3'd3, 4'h9, 64'h0);
      for (int b = 0; b < 4; b++) begin
         if (b == 2) begin
            // host0 pauses mid-burst: nothing forwarded, host1 still locked out
            drive_a(0, 1'b0, 3'd0, 3'd5, 4'h1, 64'h0);
            #1;
            checks++; if (dv.a_valid !== 1'b0) begin errors++; $display("FAIL burst_gap_valid: got %b want 0", dv.a_valid); end
            checks++; if (h1.a_ready !== 1'b0) begin errors++; $display("FAIL burst_gap_h1_ready: got %b want 0", h1.a_ready); end
            tick();
         end
         drive_a(0, 1'b1, 3'd0, 3'd5, 4'h1, 64'hD0 + 64'(b));
         #1;
         checks++; if (dv.a_source !== 4'h1) begin errors++; $display("FAIL burst_b%0d_source: got %h want 1", b, dv.a_source); end
         checks++; if (dv.a_data !== 64'hD0 + 64'(b)) begin errors++; $display("FAIL burst_b%0d_data: got %h want %h", b, dv.a_data, 64'hD0 + 64'(b)); end
         checks++; if (h0.a_ready !== 1'b1) begin errors++; $display("FAIL burst_b%0d_h0_ready: got %b want 1", b, h0.a_ready); end
         checks++; if (h1.a_ready !== 1'b0) begin errors++; $display("FAIL burst_b%0d_h1_ready: got %b want 0", b, h1.a_ready); end
         tick();
      end
      drive_a(0, 1'b0, 3'd0, 3'd5, 4'h1, 64'h0);
      #1;
      checks++; if (dv.a_source !== 4'h9) begin errors++; $display("FAIL burst_after_source: got %h want 9", dv.a_source); end
      checks++; if (h1.a_ready !== 1'b1) begin errors++; $display("FAIL burst_after_h1_ready: got %b want 1", h1.a_ready); end
      tick();
      drive_a(1, 1'b0, 3'd4, 3'd3, 4'h9, 64'h0);
      $display("test_burst: four host0 PutFullData beats then host1 Get src 9");
   endtask

   task automatic test_hold();
      // single host0 Get moves the pointer to prefer host1
      drive_a(0, 1'b1, 3'd4, 3'd3, 4'h4, 64'h0);
      #1;
      checks++; if (dv.a_source !== 4'h4) begin errors++; $display("FAIL hold_pre_source: got %h want 4", dv.a_source); end
      tick();
      dv.a_ready = 1'b0;
      drive_a(0, 1'b1, 3'd4, 3'd3, 4'h3, 64'h0);
      for (int c = 0; c < 3; c++) begin
         if (c == 1) drive_a(1, 1'b1, 3'd4, 3'd3, 4'hB, 64'h0);
         #1;
         checks++; if (dv.a_valid !== 1'b1) begin errors++; $display("FAIL hold_c%0d_valid: got %b want 1", c, dv.a_valid); end
         checks++; if (dv.a_source !== 4'h3) begin errors++; $display("FAIL hold_c%0d_source: got %h want 3", c, dv.a_source); end
         checks++; if (h0.a_ready !== 1'b0) begin errors++; $display("FAIL hold_c%0d_h0_ready: got %b want 0", c, h0.a_ready); end
         checks++; if (h1.a_ready !== 1'b0) begin errors++; $display("FAIL hold_c%0d_h1_ready: got %b want 0", c, h1.a_ready); end
         tick();
      end
      dv.a_ready = 1'b1;
      #1;
      checks++; if (dv.a_source !== 4'h3) begin errors++; $display("FAIL hold_release_source: got %h want 3", dv.a_source); end
      checks++; if (h0.a_ready !== 1'b1) begin errors++; $display("FAIL hold_release_h0_ready: got %b want 1", h0.a_ready); end
      tick();
      drive_a(0, 1'b0, 3'd4, 3'd3, 4'h3, 64'h0);
      #1;
      checks++; if (dv.a_source !== 4'hB) begin errors++; $display("FAIL hold_next_source: got %h want b", dv.a_source); end
      checks++; if (h1.a_ready !== 1'b1) begin errors++; $display("FAIL hold_next_h1_ready: got %b want 1", h1.a_ready); end
      tick();
      drive_a(1, 1'b0, 3'd4, 3'd3, 4'hB, 64'h0);
      $display("test_hold: stalled host0 beat src 3 kept until handshake, then host1 src b");
   endtask

   task automatic test_d_routing();
      dv.d_valid = 1'b1; dv.d_source = 4'h9; dv.d_data = 64'hCAFE; h0.d_ready = 1'b1; h1.d_ready = 1'b1;
      #1;
      checks++; if (h1.d_valid !== 1'b1) begin errors++; $display("FAIL d9_h1_valid: got %b want 1", h1.d_valid); end
      checks++; if (h0.d_valid !== 1'b0) begin errors++; $display("FAIL d9_h0_valid: got %b want 0", h0.d_valid); end
      checks++; if (h0.d_data !== 64'hCAFE) begin errors++; $display("FAIL d9_h0_data: got %h want cafe", h0.d_data); end
      checks++; if (dv.d_ready !== 1'b1) begin errors++; $display("FAIL d9_ready: got %b want 1", dv.d_ready); end
      h1.d_ready = 1'b0;
      #1;
      checks++; if (dv.d_ready !== 1'b0) begin errors++; $display("FAIL d9_ready_low: got %b want 0", dv.d_ready); end
      dv.d_source = 4'h3;
      #1;
      checks++; if (h0.d_valid !== 1'b1) begin errors++; $display("FAIL d3_h0_valid: got %b want 1", h0.d_valid); end
      checks++; if (h1.d_valid !== 1'b0) begin errors++; $display("FAIL d3_h1_valid: got %b want 0", h1.d_valid); end
      checks++; if (dv.d_ready !== 1'b1) begin errors++; $display("FAIL d3_ready: got %b want 1", dv.d_ready); end
      h0.d_ready = 1'b0;
      #1;
      checks++; if (dv.d_ready !== 1'b0) begin errors++; $display("FAIL d3_ready_low: got %b want 0", dv.d_ready); end
      checks++; if ({h0.b_valid, h1.c_ready, h0.e_ready, dv.c_valid, dv.e_valid} !== 5'b0) begin errors++; $display("FAIL tieoff_zero: got %b want 00000", {h0.b_valid, h1.c_ready, h0.e_ready, dv.c_valid, dv.e_valid}); end
      checks++; if (dv.b_ready !== 1'b1) begin errors++; $display("FAIL tieoff_b_ready: got %b want 1", dv.b_ready); end
      dv.d_valid = 1'b0; h0.d_ready = 1'b1; h1.d_ready = 1'b1;
      $display("test_d_routing: src 9 to host1, src 3 to host0, tie-offs constant");
   endtask

   task automatic test_reset_mid_burst();
      // host0 Get moves the pointer to prefer host1 before the host1 burst
      drive_a(0, 1'b1, 3'd4, 3'd3, 4'h6, 64'h0);
      tick();
      drive_a(0, 1'b0, 3'd4, 3'd3, 4'h6, 64'h0);
      for (int b = 0; b < 2; b++) begin
         drive_a(1, 1'b1, 3'd0, 3'd5, 4'hC, 64'hE0 + 64'(b));
         #1;
         checks++; if (dv.a_source !== 4'hC) begin errors++; $display("FAIL rstb_b%0d_source: got %h want c", b, dv.a_source); end
         checks++; if (h1.a_ready !== 1'b1) begin errors++; $display("FAIL rstb_b%0d_h1_ready: got %b want 1", b, h1.a_ready); end
         tick();
      end
      rst = 1'b1;
      #1;
      checks++; if (dv.a_valid !== 1'b0) begin errors++; $display("FAIL rstb_valid_in_reset: got %b want 0", dv.a_valid); end
      checks++; if (h1.a_ready !== 1'b0) begin errors++; $display("FAIL rstb_h1_ready_in_reset: got %b want 0", h1.a_ready); end
      tick();
      rst = 1'b0;
      drive_a(1, 1'b1, 3'd4, 3'd3, 4'hD, 64'h0);
      drive_a(0, 1'b1, 3'd4, 3'd3, 4'h5, 64'h0);
      #1;
      checks++; if (dv.a_source !== 4'h5) begin errors++; $display("FAIL rstb_fresh_source: got %h want 5", dv.a_source); end
      checks++; if (dv.a_opcode !== 3'd4) begin errors++; $display("FAIL rstb_fresh_opcode: got %0d want 4", dv.a_opcode); end
      checks++; if (h0.a_ready !== 1'b1) begin errors++; $display("FAIL rstb_fresh_h0_ready: got %b want 1", h0.a_ready); end
      checks++; if (h1.a_ready !== 1'b0) begin errors++; $display("FAIL rstb_fresh_h1_ready: got %b want 0", h1.a_ready); end
      tick();
      drive_a(0, 1'b0, 3'd4, 3'd3, 4'h5, 64'h0);
      #1;
      checks++; if (dv.a_source !== 4'hD) begin errors++; $display("FAIL rstb_next_source: got %h want d", dv.a_source); end
      tick();
      drive_a(1, 1'b0, 3'd4, 3'd3, 4'hD, 64'h0);
      $display("test_reset_mid_burst: reset after beat 2, host0 Get src 5 granted first");
   endtask

`ifdef TL_SOURCE_MERGER_A_REG_EN
   task automatic test_reg_slice();
      drive_a(1, 1'b0, 3'd4, 3'd3, 4'h0, 64'h0);
      drive_a(0, 1'b1, 3'd4, 3'd3, 4'h0, 64'h0);
      rst = 1'b0;
      dv.a_ready = 1'b1;
      #1;
      checks++; if (dv.a_valid !== 1'b0) begin errors++; $display("FAIL slice_c0_valid: got %b want 0", dv.a_valid); end
      checks++; if (h0.a_ready !== 1'b1) begin errors++; $display("FAIL slice_c0_h0_ready: got %b want 1", h0.a_ready); end
      tick();
      for (int i = 1; i < 4; i++) begin
         drive_a(0, 1'b1, 3'd4, 3'd3, 4'(i), 64'h0);
         #1;
         checks++; if (dv.a_valid !== 1'b1) begin errors++; $display("FAIL slice_c%0d_valid: got %b want 1", i, dv.a_valid); end
         checks++; if (dv.a_source !== 4'(i - 1)) begin errors++; $display("FAIL slice_c%0d_source: got %h want %h", i, dv.a_source, 4'(i - 1)); end
         checks++; if (h0.a_ready !== 1'b1) begin errors++; $display("FAIL slice_c%0d_h0_ready: got %b want 1", i, h0.a_ready); end
         tick();
      end
      drive_a(0, 1'b0, 3'd4, 3'd3, 4'h3, 64'h0);
      #1;
      checks++; if (dv.a_source !== 4'h3) begin errors++; $display("FAIL slice_last_source: got %h want 3", dv.a_source); end
      tick();
      checks++; if (dv.a_valid !== 1'b0) begin errors++; $display("FAIL slice_drained_valid: got %b want 0", dv.a_valid); end
      $display("test_reg_slice: back-to-back host0 Gets one cycle late at full rate");
   endtask
`endif

   initial begin
      rst = 1'b1;
      h0.d_ready = 1'b1; h1.d_ready = 1'b1;
      h0.b_ready = 1'b0; h0.c_valid = 1'b0; h0.e_valid = 1'b0;
      h1.b_ready = 1'b0; h1.c_valid = 1'b0; h1.e_valid = 1'b0;
      dv.a_ready = 1'b1; dv.b_valid = 1'b0; dv.c_ready = 1'b0; dv.e_ready = 1'b0;
      dv.d_valid = 1'b0; dv.d_opcode = 3'd1; dv.d_param = 2'd0; dv.d_size = 3'd3;
      dv.d_source = 4'h0; dv.d_sink = 1'b0; dv.d_denied = 1'b0; dv.d_data = 64'h0; dv.d_corrupt = 1'b0;
      test_reset();
`ifdef TL_SOURCE_MERGER_A_REG_EN
      test_d_routing();
      test_reg_slice();
`else
      test_same_cycle();
      test_burst();
      test_hold();
      test_d_routing();
      test_reset_mid_burst();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
